// File: rtl/fsmc_reg_ctrl_pkg.sv
// Shared register map, bit positions and FSM state encoding for the FSMC slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fsmc_reg_ctrl_pkg;

    localparam logic [15:0] ID_VALUE_DEF = 16'hF5C1;

    // Register indices
    localparam int REG_ID      = 0;
    localparam int REG_LED     = 1;
    localparam int REG_COUNT   = 2;
    localparam int REG_SCRATCH = 3;
    localparam int REG_CTRL    = 4;
    localparam int REG_STATUS  = 5;
    localparam int REG_WRCNT   = 6;

    // CTRL / STATUS bit positions
    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_SRC_BIT    = 1;
    localparam int STATUS_LOCK_BIT = 0;
    localparam int STATUS_PERR_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_READ     = 2'd2,
        ST_WAIT_END = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/fsmc_reg_ctrl_regfile.sv
// Register file: write decode/commit, combinational read mux, LED source select.
// Latency: register updates on the edge after wr_en_i; read mux is combinational.
// Backpressure: none; every wr_en_i pulse is accepted and counted in WRCNT.
module fsmc_regfile
    import fsmc_reg_ctrl_pkg::*;
#(
    parameter int          ADDR_W   = 4,
    parameter logic [15:0] ID_VALUE = ID_VALUE_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [15:0]       wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [15:0]       rd_data_o,
    input  logic [15:0]       pulse_count_i,
    input  logic              pll_lock_i,
    input  logic              perr_set_i,
    output logic              cnt_clear_o,
    output logic [7:0]        leds_o
);

    logic [15:0] led_q;
    logic [15:0] scratch_q;
    logic [15:0] wrcnt_q;
    logic        src_q;
    logic        perr_q;
    logic        cnt_clear_q;
    logic [31:0] wr_idx;
    logic [31:0] rd_idx;

    assign wr_idx = 32'(wr_addr_i);
    assign rd_idx = 32'(rd_addr_i);

    // Commit writes; clear strobe self-clears; a new protocol error beats a clear request
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            led_q       <= '0;
            scratch_q   <= '0;
            wrcnt_q     <= '0;
            src_q       <= 1'b0;
            perr_q      <= 1'b0;
            cnt_clear_q <= 1'b0;
        end else begin
            cnt_clear_q <= 1'b0;
            if (perr_set_i) begin
                perr_q <= 1'b1;
            end
            if (wr_en_i) begin
                wrcnt_q <= wrcnt_q + 16'd1;
                case (wr_idx)
                    REG_LED:     led_q     <= wr_data_i;
                    REG_SCRATCH: scratch_q <= wr_data_i;
                    REG_CTRL: begin
                        src_q       <= wr_data_i[CTRL_SRC_BIT];
                        cnt_clear_q <= wr_data_i[CTRL_CLEAR_BIT];
                    end
                    REG_STATUS: begin
                        if (wr_data_i[STATUS_PERR_BIT] && !perr_set_i) begin
                            perr_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read mux; COUNT is live here and gets snapshotted by the caller on read entry
    always_comb begin
        rd_data_o = '0;
        case (rd_idx)
            REG_ID:      rd_data_o = ID_VALUE;
            REG_LED:     rd_data_o = led_q;
            REG_COUNT:   rd_data_o = pulse_count_i;
            REG_SCRATCH: rd_data_o = scratch_q;
            REG_CTRL:    rd_data_o[CTRL_SRC_BIT] = src_q;
            REG_STATUS: begin
                rd_data_o[STATUS_LOCK_BIT] = pll_lock_i;
                rd_data_o[STATUS_PERR_BIT] = perr_q;
            end
            REG_WRCNT:   rd_data_o = wrcnt_q;
            default:     rd_data_o = '0;
        endcase
    end

    assign cnt_clear_o = cnt_clear_q;
    assign leds_o      = src_q ? pulse_count_i[7:0] : led_q[7:0];

endmodule

// File: rtl/fsmc_reg_ctrl.sv
// FSMC NOR/SRAM slave: synchronises the async bus and sequences reads/writes into the register file.
// Latency: 2 clk sync, read data latched 1 clk later; write lands 2 clk after the synced nwe/ne rise.
// Backpressure: none; the host must keep ADDSET+DATAST >= 4 clk so read data is ready when sampled.
module fsmc_reg_ctrl
    import fsmc_reg_ctrl_pkg::*;
#(
    parameter int          ADDR_W   = 4,
    parameter logic [15:0] ID_VALUE = ID_VALUE_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              fsmc_ne,
    input  logic              fsmc_noe,
    input  logic              fsmc_nwe,
    input  logic [ADDR_W-1:0] fsmc_addr,
    input  logic [15:0]       fsmc_d_in,
    output logic [15:0]       fsmc_d_out,
    output logic              fsmc_d_oe,
    input  logic [15:0]       pulse_count,
    input  logic              pll_lock,
    output logic              cnt_clear,
    output logic [7:0]        leds
);

    localparam int SYNC_W = 3 + ADDR_W + 16;
    // Strobes idle high so reset never looks like an access in flight
    localparam logic [SYNC_W-1:0] SYNC_RST = {3'b111, {(ADDR_W + 16){1'b0}}};

    logic [SYNC_W-1:0] sync1_q;
    logic [SYNC_W-1:0] sync2_q;
    logic              ne_s;
    logic              noe_s;
    logic              nwe_s;
    logic [ADDR_W-1:0] addr_s;
    logic [15:0]       d_s;
    logic              proto_err;

    fsm_state_t        state_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [15:0]       hold_data_q;
    logic              wr_en_q;
    logic              perr_set_q;
    logic [15:0]       rd_data_q;
    logic              rd_valid_q;
    logic [15:0]       rf_rdata;

    // Two-flop synchroniser for the whole bus, so every field sees the same latency
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
        end else begin
            sync1_q <= {fsmc_ne, fsmc_noe, fsmc_nwe, fsmc_addr, fsmc_d_in};
            sync2_q <= sync1_q;
        end
    end

    assign ne_s      = sync2_q[SYNC_W-1];
    assign noe_s     = sync2_q[SYNC_W-2];
    assign nwe_s     = sync2_q[SYNC_W-3];
    assign addr_s    = sync2_q[16 +: ADDR_W];
    assign d_s       = sync2_q[15:0];
    assign proto_err = !ne_s && !noe_s && !nwe_s;

    // Access sequencer: capture while nwe low, commit on its rise; snapshot read data on entry
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            wr_en_q     <= 1'b0;
            perr_set_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_en_q    <= 1'b0;
            perr_set_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (proto_err) begin
                        state_q    <= ST_WAIT_END;
                        perr_set_q <= 1'b1;
                    end else if (!ne_s && !nwe_s) begin
                        state_q     <= ST_WRITE;
                        hold_addr_q <= addr_s;
                        hold_data_q <= d_s;
                    end else if (!ne_s && !noe_s) begin
                        state_q    <= ST_READ;
                        rd_data_q  <= rf_rdata;
                        rd_valid_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (proto_err) begin
                        state_q    <= ST_WAIT_END;
                        perr_set_q <= 1'b1;
                    end else if (!ne_s && !nwe_s) begin
                        hold_addr_q <= addr_s;
                        hold_data_q <= d_s;
                    end else begin
                        state_q <= ST_IDLE;
                        wr_en_q <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (proto_err) begin
                        state_q    <= ST_WAIT_END;
                        perr_set_q <= 1'b1;
                        rd_valid_q <= 1'b0;
                    end else if (ne_s || noe_s) begin
                        state_q    <= ST_IDLE;
                        rd_valid_q <= 1'b0;
                    end
                end
                default: begin
                    if (ne_s) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    fsmc_regfile #(
        .ADDR_W   (ADDR_W),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk           (clk),
        .nrst          (nrst),
        .wr_en_i       (wr_en_q),
        .wr_addr_i     (hold_addr_q),
        .wr_data_i     (hold_data_q),
        .rd_addr_i     (addr_s),
        .rd_data_o     (rf_rdata),
        .pulse_count_i (pulse_count),
        .pll_lock_i    (pll_lock),
        .perr_set_i    (perr_set_q),
        .cnt_clear_o   (cnt_clear),
        .leds_o        (leds)
    );

    // Raw pins gate the pad so the bus is released without waiting for the synchroniser
    assign fsmc_d_oe  = rd_valid_q & ~fsmc_ne & ~fsmc_noe;
    assign fsmc_d_out = rd_data_q;

endmodule

// File: tb/tb_fsmc_reg_ctrl.sv
// Directed bench for the FSMC slave register controller.
// Latency: n/a.
// Backpressure: n/a.
module tb_fsmc_reg_ctrl;

    logic        clk;
    logic        nrst;
    logic        fsmc_ne;
    logic        fsmc_noe;
    logic        fsmc_nwe;
    logic [3:0]  fsmc_addr;
    logic [15:0] fsmc_d_in;
    logic [15:0] fsmc_d_out;
    logic        fsmc_d_oe;
    logic [15:0] pulse_count;
    logic        pll_lock;
    logic        cnt_clear;
    logic [7:0]  leds;

    int checks;
    int errors;
    int clr_cycles;
    logic [15:0] exp_wrcnt;
    logic [15:0] rd;
    logic        oe;
    int          clr_before;

    fsmc_reg_ctrl #(
        .ADDR_W   (4),
        .ID_VALUE (16'hF5C1)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .fsmc_ne     (fsmc_ne),
        .fsmc_noe    (fsmc_noe),
        .fsmc_nwe    (fsmc_nwe),
        .fsmc_addr   (fsmc_addr),
        .fsmc_d_in   (fsmc_d_in),
        .fsmc_d_out  (fsmc_d_out),
        .fsmc_d_oe   (fsmc_d_oe),
        .pulse_count (pulse_count),
        .pll_lock    (pll_lock),
        .cnt_clear   (cnt_clear),
        .leds        (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial clr_cycles = 0;
    always @(posedge clk) begin
        if (cnt_clear) clr_cycles <= clr_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        fsmc_ne = 1'b0; fsmc_addr = a; fsmc_d_in = d;
        @(negedge clk);
        fsmc_nwe = 1'b0;
        repeat (4) @(negedge clk);
        fsmc_nwe = 1'b1;
        @(negedge clk);
        fsmc_ne = 1'b1;
        repeat (4) @(negedge clk);
        exp_wrcnt = exp_wrcnt + 16'd1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] d, output logic oe_seen);
        @(negedge clk);
        fsmc_ne = 1'b0; fsmc_addr = a; fsmc_noe = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        d = fsmc_d_out;
        oe_seen = fsmc_d_oe;
        @(negedge clk);
        fsmc_noe = 1'b1; fsmc_ne = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        exp_wrcnt = 16'd0;
    endtask

    initial begin
        checks = 0; errors = 0; exp_wrcnt = 16'd0;
        nrst = 1'b0; fsmc_ne = 1'b1; fsmc_noe = 1'b1; fsmc_nwe = 1'b1;
        fsmc_addr = 4'd0; fsmc_d_in = 16'd0; pulse_count = 16'd0; pll_lock = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_d_out", 32'(fsmc_d_out), 32'h0);
        check("rst_d_oe", 32'(fsmc_d_oe), 32'h0);
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_clear", 32'(cnt_clear), 32'h0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: ID read, pad enable follows raw ne/noe
        @(negedge clk);
        fsmc_ne = 1'b0; fsmc_addr = 4'd0;
        #1 check("oe_before_noe", 32'(fsmc_d_oe), 32'h0);
        fsmc_noe = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("id_data", 32'(fsmc_d_out), 32'hF5C1);
        check("id_oe", 32'(fsmc_d_oe), 32'h1);
        fsmc_noe = 1'b1;
        #1 check("oe_fast_release", 32'(fsmc_d_oe), 32'h0);
        fsmc_ne = 1'b1;
        repeat (3) @(negedge clk);
        check("leds_after_rst", 32'(leds), 32'h0);

        // 2: LED write lands within 4 clk of nwe rise
        @(negedge clk);
        fsmc_ne = 1'b0; fsmc_addr = 4'd1; fsmc_d_in = 16'h00A5;
        @(negedge clk);
        fsmc_nwe = 1'b0;
        repeat (4) @(negedge clk);
        fsmc_nwe = 1'b1;
        repeat (4) @(negedge clk);
        check("leds_a5", 32'(leds), 32'hA5);
        fsmc_ne = 1'b1;
        repeat (3) @(negedge clk);
        exp_wrcnt = exp_wrcnt + 16'd1;
        bus_read(4'd1, rd, oe);
        check("led_readback", 32'(rd), 32'h00A5);
        bus_read(4'd6, rd, oe);
        check("wrcnt_1", 32'(rd), 32'(exp_wrcnt));

        // SCRATCH full width, ID write ignored, unmapped reads zero
        bus_write(4'd3, 16'hBEEF);
        bus_read(4'd3, rd, oe);
        check("scratch", 32'(rd), 32'hBEEF);
        bus_write(4'd0, 16'h1111);
        bus_read(4'd0, rd, oe);
        check("id_ro", 32'(rd), 32'hF5C1);
        bus_write(4'd9, 16'h5555);
        bus_read(4'd9, rd, oe);
        check("unmapped", 32'(rd), 32'h0);
        bus_read(4'd6, rd, oe);
        check("wrcnt_counts_ignored", 32'(rd), 32'(exp_wrcnt));

        // 3: COUNT snapshot, clear strobe
        pulse_count = 16'h1234;
        @(negedge clk);
        fsmc_ne = 1'b0; fsmc_addr = 4'd2; fsmc_noe = 1'b0;
        repeat (5) @(negedge clk);
        pulse_count = 16'h9999;
        repeat (2) @(negedge clk);
        #1 check("count_snapshot", 32'(fsmc_d_out), 32'h1234);
        fsmc_noe = 1'b1; fsmc_ne = 1'b1;
        repeat (3) @(negedge clk);
        pulse_count = 16'h1234;
        clr_before = clr_cycles;
        bus_write(4'd4, 16'h0001);
        repeat (2) @(negedge clk);
        check("clear_one_cycle", 32'(clr_cycles - clr_before), 32'd1);
        bus_read(4'd4, rd, oe);
        check("ctrl_reads_0", 32'(rd), 32'h0);

        // 4: LED source from live count
        pulse_count = 16'h0077;
        bus_write(4'd4, 16'h0002);
        #1 check("leds_count77", 32'(leds), 32'h77);
        pulse_count = 16'h0078;
        #1 check("leds_count78", 32'(leds), 32'h78);
        bus_read(4'd4, rd, oe);
        check("ctrl_src", 32'(rd), 32'h2);
        bus_write(4'd4, 16'h0000);
        #1 check("leds_back_reg", 32'(leds), 32'hA5);

        // 5: protocol error, no commit, sticky flag and clear
        @(negedge clk);
        fsmc_ne = 1'b0; fsmc_addr = 4'd3; fsmc_d_in = 16'hDEAD;
        @(negedge clk);
        fsmc_noe = 1'b0; fsmc_nwe = 1'b0;
        repeat (4) @(negedge clk);
        fsmc_noe = 1'b1; fsmc_nwe = 1'b1;
        @(negedge clk);
        fsmc_ne = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(4'd3, rd, oe);
        check("perr_no_commit", 32'(rd), 32'hBEEF);
        bus_read(4'd5, rd, oe);
        check("status_perr", 32'(rd), 32'h3);
        bus_read(4'd6, rd, oe);
        check("wrcnt_perr", 32'(rd), 32'(exp_wrcnt));
        bus_write(4'd5, 16'h0002);
        bus_read(4'd5, rd, oe);
        check("status_cleared", 32'(rd), 32'h1);

        // 6: WRCNT wrap via back-to-back writes with ne held low
        do_reset();
        @(negedge clk);
        fsmc_ne = 1'b0; fsmc_addr = 4'd7; fsmc_d_in = 16'h0000;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk) fsmc_nwe = 1'b0;
            @(negedge clk) fsmc_nwe = 1'b1;
        end
        exp_wrcnt = exp_wrcnt + 16'd65535;
        @(negedge clk) fsmc_ne = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(4'd6, rd, oe);
        check("wrcnt_ffff", 32'(rd), 32'hFFFF);
        bus_write(4'd7, 16'h0000);
        bus_read(4'd6, rd, oe);
        check("wrcnt_wrap", 32'(rd), 32'(exp_wrcnt));

        // Reset mid-write: no commit, outputs at reset values
        bus_write(4'd1, 16'h00C3);
        #1 check("leds_c3", 32'(leds), 32'hC3);
        @(negedge clk);
        fsmc_ne = 1'b0; fsmc_addr = 4'd1; fsmc_d_in = 16'h003C;
        @(negedge clk);
        fsmc_nwe = 1'b0;
        repeat (4) @(negedge clk);
        nrst = 1'b0;
        #1;
        check("mid_rst_leds", 32'(leds), 32'h0);
        check("mid_rst_oe", 32'(fsmc_d_oe), 32'h0);
        check("mid_rst_dout", 32'(fsmc_d_out), 32'h0);
        @(negedge clk);
        fsmc_nwe = 1'b1; fsmc_ne = 1'b1;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_leds", 32'(leds), 32'h0);
        bus_read(4'd1, rd, oe);
        check("post_rst_led_reg", 32'(rd), 32'h0);
        bus_read(4'd6, rd, oe);
        check("post_rst_wrcnt", 32'(rd), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
